// File: rtl/melody_sequencer_if.sv
// Note-ROM bus between melody_sequencer (master) and the ROM it owns (slave).
// The ROM read is combinational: rom_data follows rom_addr in the same cycle.
interface melody_sequencer_if;
  logic [5:0] rom_addr;
  logic [9:0] rom_data;

  modport master (output rom_addr, input  rom_data);
  modport slave  (input  rom_addr, output rom_data);
endinterface

// File: rtl/melody_sequencer.sv
// Song player for the buzzer: steps the note ROM, times notes in beats with a silent
// gap after each one, and lets manual key presses override song output.
module melody_sequencer #(
  parameter int unsigned BEAT_TICKS = 12_500_000,
  parameter int unsigned GAP_TICKS  = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              song_sel,
  input  logic              manual_on,
  input  logic [4:0]        manual_key,
  melody_sequencer_if.master rom,
  output logic              key_on,
  output logic [4:0]        key,
  output logic              busy,
  output logic              done
);

  localparam longint unsigned MAX_NOTE_TICKS = 64'(BEAT_TICKS) * 64'd8;

  if (MAX_NOTE_TICKS > 64'hFFFF_FFFF || GAP_TICKS == 0 || BEAT_TICKS <= GAP_TICKS) begin : g_param_check
    $error("melody_sequencer: BEAT_TICKS/GAP_TICKS out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_PLAY, S_GAP, S_PAUSED, S_DONE
  } state_e;

  state_e      state_q, state_d;
  state_e      ret_q, ret_d;
  logic [31:0] cnt_q, cnt_d;
  logic        rest_q, rest_d;
  logic [4:0]  note_key_q, note_key_d;
  logic [5:0]  rom_addr_q, rom_addr_d;
  logic        key_on_q, key_on_d;
  logic [4:0]  key_q, key_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] note_ticks;

  assign note_ticks = (32'(rom.rom_data[7:5]) + 32'd1) * BEAT_TICKS - GAP_TICKS;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ret_q      <= S_IDLE;
      cnt_q      <= '0;
      rest_q     <= 1'b0;
      note_key_q <= '0;
      rom_addr_q <= '0;
      key_on_q   <= 1'b0;
      key_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      cnt_q      <= cnt_d;
      rest_q     <= rest_d;
      note_key_q <= note_key_d;
      rom_addr_q <= rom_addr_d;
      key_on_q   <= key_on_d;
      key_q      <= key_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    cnt_d      = cnt_q;
    rest_d     = rest_q;
    note_key_d = note_key_q;
    rom_addr_d = rom_addr_q;
    if (stop && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !stop) begin
            rom_addr_d = {song_sel, 5'd0};
            state_d    = S_FETCH;
          end
        end
        S_FETCH: begin
          if (rom.rom_data[9]) begin
            state_d = S_DONE;
          end else begin
            rest_d     = rom.rom_data[8];
            note_key_d = rom.rom_data[4:0];
            cnt_d      = note_ticks;
            state_d    = S_PLAY;
          end
        end
        S_PLAY, S_GAP: begin
          // Pausing leaves the count untouched, so the paused cycle is replayed on resume.
          if (pause) begin
            ret_d   = state_q;
            state_d = S_PAUSED;
          end else if (cnt_q > 32'd1) begin
            cnt_d = cnt_q - 32'd1;
          end else if (state_q == S_PLAY) begin
            cnt_d   = GAP_TICKS;
            state_d = S_GAP;
          end else if (rom_addr_q[4:0] == 5'd31) begin
            state_d = S_DONE;
          end else begin
            rom_addr_d = rom_addr_q + 6'd1;
            state_d    = S_FETCH;
          end
        end
        S_PAUSED: begin
          if (!pause) state_d = ret_q;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so every input shows up one cycle later.
  always_comb begin
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    key_on_d = 1'b0;
    key_d    = (state_d == S_IDLE) ? '0 : note_key_d;
    if (manual_on) begin
      key_on_d = 1'b1;
      key_d    = manual_key;
    end else if (state_d == S_PLAY) begin
      key_on_d = ~rest_d;
    end
  end

  assign rom.rom_addr = rom_addr_q;
  assign key_on       = key_on_q;
  assign key          = key_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
